// File: rtl/mode_mux.sv
// 4-way arbiter fused with a data mux: fixed-priority or round-robin selection, registered grant/data.
// Optional macro MODE_MUX_VALID_EN adds a registered `valid` output equal to |grant.
module mode_mux #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [DATA_W-1:0]    data_in [NUM_REQ-1:0],
  output logic [DATA_W-1:0]    data_out,
`ifdef MODE_MUX_VALID_EN
  output logic [NUM_REQ-1:0]   grant,
  output logic                 valid
`else
  output logic [NUM_REQ-1:0]   grant
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_grant;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_last;
  int                 w_start;
  logic               w_found;
  logic [IDX_W-1:0]   w_idx;

  // Fixed priority always searches from index 0; round robin starts just past the last winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_start = 0;
    w_found = 1'b0;
    w_idx   = '0;
    if (mode) begin
      w_start = (int'(r_last) + 1) % NUM_REQ;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[(w_start + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'((w_start + k) % NUM_REQ);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_data  <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_grant <= '0;
      r_data  <= '0;
      if (w_found) begin
        r_grant[w_idx] <= 1'b1;
        r_data         <= data_in[w_idx];
        r_last         <= w_idx;
      end
    end
  end

  assign grant    = r_grant;
  assign data_out = r_data;

`ifdef MODE_MUX_VALID_EN
  logic r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_found;
    end
  end

  assign valid = r_valid;
`endif

endmodule

// File: tb/tb_mode_mux.sv
// Directed and model-checked bench for mode_mux; data words A1/B2/C3/D4 on requesters 0..3.
// Build with MODE_MUX_VALID_EN defined to also check the valid output.
module tb_mode_mux;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] req;
  logic [7:0] data_in [3:0];
  logic [7:0] data_out;
  logic [3:0] grant;
`ifdef MODE_MUX_VALID_EN
  logic       valid;
`endif

  int checks = 0;
  int errors = 0;
  int ref_last;

  mode_mux #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .req      (req),
    .data_in  (data_in),
    .data_out (data_out),
`ifdef MODE_MUX_VALID_EN
    .grant    (grant),
    .valid    (valid)
`else
    .grant    (grant)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic r, input logic m, input logic [3:0] q);
    @(negedge clk);
    rst  = r;
    mode = m;
    req  = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eg, input logic [7:0] ed);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".data"}, 32'(data_out), 32'(ed));
`ifdef MODE_MUX_VALID_EN
    check({tag, ".valid"}, 32'(valid), 32'(|eg));
`endif
  endtask

  function automatic logic [7:0] word_of(input int idx);
    case (idx)
      0: return 8'hA1;
      1: return 8'hB2;
      2: return 8'hC3;
      default: return 8'hD4;
    endcase
  endfunction

  logic [3:0] rq;
  logic [3:0] eg;
  logic [7:0] ed;
  int         start;
  bit         found;

  initial begin
    rst = 1'b0; mode = 1'b0; req = 4'b0000;
    data_in[0] = 8'hA1; data_in[1] = 8'hB2; data_in[2] = 8'hC3; data_in[3] = 8'hD4;

    step(1'b1, 1'b0, 4'b1111); expect_out("reset", 4'b0000, 8'h00);

    step(1'b0, 1'b0, 4'b1111); expect_out("fix_1111", 4'b0001, 8'hA1);
    step(1'b0, 1'b0, 4'b0110); expect_out("fix_0110", 4'b0010, 8'hB2);
    step(1'b0, 1'b0, 4'b0001); expect_out("fix_0001", 4'b0001, 8'hA1);

    step(1'b0, 1'b1, 4'b1111); expect_out("rr_1", 4'b0010, 8'hB2);
    step(1'b0, 1'b1, 4'b1111); expect_out("rr_2", 4'b0100, 8'hC3);
    step(1'b0, 1'b1, 4'b1111); expect_out("rr_3", 4'b1000, 8'hD4);
    step(1'b0, 1'b1, 4'b1111); expect_out("rr_4", 4'b0001, 8'hA1);
    step(1'b0, 1'b1, 4'b1111); expect_out("rr_5", 4'b0010, 8'hB2);
    step(1'b0, 1'b1, 4'b1111); expect_out("rr_6", 4'b0100, 8'hC3);

    step(1'b0, 1'b1, 4'b1001); expect_out("rr_skip", 4'b1000, 8'hD4);
    step(1'b0, 1'b1, 4'b1001); expect_out("rr_wrap", 4'b0001, 8'hA1);

    step(1'b0, 1'b1, 4'b0000); expect_out("idle_rr", 4'b0000, 8'h00);
    step(1'b0, 1'b1, 4'b1111); expect_out("after_idle_rr", 4'b0010, 8'hB2);
    step(1'b0, 1'b0, 4'b0000); expect_out("idle_fix", 4'b0000, 8'h00);
    step(1'b0, 1'b1, 4'b1111); expect_out("after_idle_fix", 4'b0100, 8'hC3);

    // Fixed-priority win moves the pointer; round robin then resumes past it.
    step(1'b0, 1'b0, 4'b1100); expect_out("fix_1100", 4'b0100, 8'hC3);
    step(1'b0, 1'b1, 4'b0111); expect_out("switch_rr", 4'b0001, 8'hA1);

    step(1'b1, 1'b1, 4'b1111); expect_out("mid_reset", 4'b0000, 8'h00);
    step(1'b0, 1'b1, 4'b1111); expect_out("post_reset", 4'b0001, 8'hA1);

    ref_last = 0;
    for (int n = 0; n < 12; n++) begin
      rq = 4'($urandom_range(0, 15));
      eg = 4'b0000;
      ed = 8'h00;
      found = 1'b0;
      start = (ref_last + 1) % 4;
      for (int k = 0; k < 4; k++) begin
        if (!found && rq[(start + k) % 4]) begin
          found = 1'b1;
          eg[(start + k) % 4] = 1'b1;
          ed = word_of((start + k) % 4);
          ref_last = (start + k) % 4;
        end
      end
      step(1'b0, 1'b1, rq);
      expect_out($sformatf("rand%0d_req%b", n, rq), eg, ed);
      check($sformatf("rand%0d_onehot", n), 32'($onehot0(grant)), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
